// File: rtl/decode_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decode_queue_pkg
// Purpose  : Shared types for the decode queue: the decoded-instruction record
//            (instruction_info_reg_t), ALU/mul/div/operand-select enums, RV32
//            opcode constants and a funct3 -> ALU-op helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package decode_queue_pkg;

  // RV32 major opcodes
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_reg    = 7'b0110011;

  // Comparator operations share the branch funct3 encoding
  localparam logic [2:0] c_cmp_blt  = 3'b100;
  localparam logic [2:0] c_cmp_bltu = 3'b110;

  typedef enum logic [3:0] {
    alu_add = 4'd0,
    alu_sub = 4'd1,
    alu_sll = 4'd2,
    alu_srl = 4'd3,
    alu_sra = 4'd4,
    alu_xor = 4'd5,
    alu_or  = 4'd6,
    alu_and = 4'd7
  } alu_op_t;

  // Second-operand source; op_b_lui marks the zero-plus-immediate form of lui
  typedef enum logic [1:0] {
    op_b_reg = 2'd0,
    op_b_imm = 2'd1,
    op_b_lui = 2'd2
  } op_b_sel_t;

  typedef enum logic [1:0] {
    mul_mul    = 2'b00,
    mul_mulh   = 2'b01,
    mul_mulhsu = 2'b10,
    mul_mulhu  = 2'b11
  } mul_type_t;

  typedef enum logic [1:0] {
    div_div  = 2'b00,
    div_divu = 2'b01,
    div_rem  = 2'b10,
    div_remu = 2'b11
  } div_type_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc_curr;
    logic [31:0] pc_next;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [4:0]  rd_s;
    logic        rs1_needed;
    logic        rs2_needed;
    logic [31:0] immediate;
    logic        op1_is_imm;
    logic        op1_is_pc;
    logic        op2_is_imm;
    op_b_sel_t   op_b_sel;
    logic        alu_en;
    alu_op_t     alu_op;
    logic        cmp_en;
    logic [2:0]  cmp_operation;
    logic        is_branch;
    logic        is_jump;
    logic        is_load;
    logic        is_store;
    logic [2:0]  mem_funct3;
    logic        is_mul;
    mul_type_t   mul_type;
    logic        is_div;
    div_type_t   div_type;
    logic        illegal;
  } instruction_info_reg_t;

  // alt selects sub (funct3=000) or sra (funct3=101); ignored otherwise
  function automatic alu_op_t f3_to_alu(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      3'b000:  op = alt ? alu_sub : alu_add;
      3'b001:  op = alu_sll;
      3'b100:  op = alu_xor;
      3'b101:  op = alt ? alu_sra : alu_srl;
      3'b110:  op = alu_or;
      3'b111:  op = alu_and;
      default: op = alu_add;
    endcase
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : decode_queue_if
// Purpose  : Fetch-side group handshake and rename-side dequeue handshake of
//            the decode queue.
// Ports    : in_valid/in_inst/in_pc/in_pc_next/in_ready  - fetch group
//            out_info/out_valid/out_ready                 - rename lanes
//            modport slave  : the queue
//            modport master : the fetch/rename environment
// Revision : 1.0 - initial release
// ============================================================================
interface decode_queue_if #(
  parameter int WIDTH = 2
);
  import decode_queue_pkg::*;

  logic [WIDTH-1:0]                        in_valid;
  logic [WIDTH*32-1:0]                     in_inst;
  logic [WIDTH*32-1:0]                     in_pc;
  logic [WIDTH*32-1:0]                     in_pc_next;
  logic                                    in_ready;
  instruction_info_reg_t [WIDTH-1:0]       out_info;
  logic [WIDTH-1:0]                        out_valid;
  logic [WIDTH-1:0]                        out_ready;

  modport slave (
    input  in_valid, in_inst, in_pc, in_pc_next, out_ready,
    output in_ready, out_info, out_valid
  );

  modport master (
    output in_valid, in_inst, in_pc, in_pc_next, out_ready,
    input  in_ready, out_info, out_valid
  );

endinterface
`default_nettype wire

// File: rtl/decode_queue_rv_decoder.sv
`default_nettype none
// ============================================================================
// Module   : rv_decoder
// Purpose  : Combinational RV32IM single-lane decoder producing an
//            instruction_info_reg_t record.
// Ports    : valid_i   - lane carries an instruction
//            inst_i    - raw 32-bit instruction
//            pc_i      - pc of the instruction
//            pc_next_i - predicted next pc
//            info_o    - decoded record
// Revision : 1.0 - initial release
// ============================================================================
module rv_decoder
  import decode_queue_pkg::*;
(
  input  logic                  valid_i,
  input  logic [31:0]           inst_i,
  input  logic [31:0]           pc_i,
  input  logic [31:0]           pc_next_i,
  output instruction_info_reg_t info_o
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] w_i_imm;
  logic [31:0] w_s_imm;
  logic [31:0] w_b_imm;
  logic [31:0] w_u_imm;
  logic [31:0] w_j_imm;
  logic        w_bad;
  logic        w_f3_slt;

  assign w_opcode = inst_i[6:0];
  assign w_funct3 = inst_i[14:12];
  assign w_funct7 = inst_i[31:25];
  assign w_f3_slt = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);

  assign w_i_imm = {{20{inst_i[31]}}, inst_i[31:20]};
  assign w_s_imm = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign w_b_imm = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign w_u_imm = {inst_i[31:12], 12'b0};
  assign w_j_imm = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  always_comb begin
    info_o          = '0;
    w_bad           = 1'b0;
    info_o.valid    = valid_i;
    info_o.pc_curr  = pc_i;
    info_o.pc_next  = pc_next_i;
    info_o.rs1_s    = inst_i[19:15];
    info_o.rs2_s    = inst_i[24:20];
    info_o.rd_s     = inst_i[11:7];
    info_o.alu_op   = alu_add;
    info_o.op_b_sel = op_b_reg;
    info_o.mul_type = mul_mul;
    info_o.div_type = div_div;

    case (w_opcode)
      c_op_lui: begin
        // Computed as 0 + u_imm: operand 0 comes from the immediate path
        info_o.immediate  = w_u_imm;
        info_o.op1_is_imm = 1'b1;
        info_o.op2_is_imm = 1'b1;
        info_o.op_b_sel   = op_b_lui;
        info_o.alu_en     = 1'b1;
      end
      c_op_auipc: begin
        info_o.immediate  = w_u_imm;
        info_o.op1_is_pc  = 1'b1;
        info_o.op2_is_imm = 1'b1;
        info_o.op_b_sel   = op_b_imm;
        info_o.alu_en     = 1'b1;
      end
      c_op_jal: begin
        info_o.immediate = w_j_imm;
        info_o.is_jump   = 1'b1;
      end
      c_op_jalr: begin
        info_o.immediate  = w_i_imm;
        info_o.is_jump    = 1'b1;
        info_o.rs1_needed = 1'b1;
        info_o.op2_is_imm = 1'b1;
        info_o.op_b_sel   = op_b_imm;
      end
      c_op_branch: begin
        info_o.immediate     = w_b_imm;
        info_o.is_branch     = 1'b1;
        info_o.cmp_en        = 1'b1;
        info_o.cmp_operation = w_funct3;
        info_o.rs1_needed    = 1'b1;
        info_o.rs2_needed    = 1'b1;
        info_o.rd_s          = 5'd0;
      end
      c_op_load: begin
        info_o.immediate  = w_i_imm;
        info_o.is_load    = 1'b1;
        info_o.mem_funct3 = w_funct3;
        info_o.rs1_needed = 1'b1;
        info_o.op2_is_imm = 1'b1;
        info_o.op_b_sel   = op_b_imm;
        info_o.alu_en     = 1'b1;
      end
      c_op_store: begin
        info_o.immediate  = w_s_imm;
        info_o.is_store   = 1'b1;
        info_o.mem_funct3 = w_funct3;
        info_o.rs1_needed = 1'b1;
        info_o.rs2_needed = 1'b1;
        info_o.op2_is_imm = 1'b1;
        info_o.op_b_sel   = op_b_imm;
        info_o.alu_en     = 1'b1;
        info_o.rd_s       = 5'd0;
      end
      c_op_imm: begin
        info_o.immediate  = w_i_imm;
        info_o.rs1_needed = 1'b1;
        info_o.op2_is_imm = 1'b1;
        info_o.op_b_sel   = op_b_imm;
        if (w_f3_slt) begin
          // slti/sltiu run on the comparator as blt/bltu
          info_o.cmp_en        = 1'b1;
          info_o.cmp_operation = w_funct3[0] ? c_cmp_bltu : c_cmp_blt;
        end else begin
          info_o.alu_en = 1'b1;
          // funct7[5] only means sra for the right shift; addi has no sub form
          info_o.alu_op = f3_to_alu(w_funct3, (w_funct3 == 3'b101) && w_funct7[5]);
        end
        // Shift-immediates reuse the funct7 field and must keep it legal
        if (w_funct3 == 3'b001 && w_funct7 != 7'b0000000)
          w_bad = 1'b1;
        if (w_funct3 == 3'b101 && w_funct7 != 7'b0000000 && w_funct7 != 7'b0100000)
          w_bad = 1'b1;
      end
      c_op_reg: begin
        info_o.rs1_needed = 1'b1;
        info_o.rs2_needed = 1'b1;
        if (w_funct7 == 7'b0000001) begin
          if (w_funct3[2]) begin
            info_o.is_div   = 1'b1;
            info_o.div_type = div_type_t'(w_funct3[1:0]);
          end else begin
            info_o.is_mul   = 1'b1;
            info_o.mul_type = mul_type_t'(w_funct3[1:0]);
          end
        end else if (w_funct7 == 7'b0000000 ||
                     (w_funct7 == 7'b0100000 && (w_funct3 == 3'b000 || w_funct3 == 3'b101))) begin
          if (w_f3_slt) begin
            info_o.cmp_en        = 1'b1;
            info_o.cmp_operation = w_funct3[0] ? c_cmp_bltu : c_cmp_blt;
          end else begin
            info_o.alu_en = 1'b1;
            info_o.alu_op = f3_to_alu(w_funct3, w_funct7[5]);
          end
        end else begin
          w_bad = 1'b1;
        end
      end
      default: w_bad = 1'b1;
    endcase

    // Illegal entries still travel in order; they just request no resources
    if (w_bad) begin
      info_o.illegal    = 1'b1;
      info_o.alu_en     = 1'b0;
      info_o.cmp_en     = 1'b0;
      info_o.rs1_needed = 1'b0;
      info_o.rs2_needed = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : decode_queue
// Purpose  : WIDTH-lane decode stage feeding a DEPTH-entry circular buffer.
//            Fetch groups are decoded combinationally, enqueued in program
//            order and offered to rename as the WIDTH oldest entries.
// Ports    : clk    - clock, rising edge
//            rst_n  - asynchronous active-low reset
//            flush  - drop all queued entries and same-cycle traffic
//            dq     - fetch/rename handshake (slave modport)
//            count  - number of occupied entries
// Revision : 1.0 - initial release
// ============================================================================
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter  int WIDTH = 2,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  decode_queue_if.slave      dq,
  output logic [PTR_W:0]     count
);

  // Group accepted only while a full WIDTH-wide group is guaranteed to fit
  localparam logic [PTR_W:0] c_ready_max = (PTR_W + 1)'(DEPTH - WIDTH);

  instruction_info_reg_t [WIDTH-1:0] w_dec;
  instruction_info_reg_t             entry_q [DEPTH];

  logic [PTR_W-1:0] head_q,  head_d;
  logic [PTR_W-1:0] tail_q,  tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W:0]   w_enq_n;
  logic [PTR_W:0]   w_deq_n;
  logic             w_accept;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_dec
    rv_decoder u_dec (
      .valid_i   (dq.in_valid[gi]),
      .inst_i    (dq.in_inst[gi*32 +: 32]),
      .pc_i      (dq.in_pc[gi*32 +: 32]),
      .pc_next_i (dq.in_pc_next[gi*32 +: 32]),
      .info_o    (w_dec[gi])
    );
  end

  for (genvar go = 0; go < WIDTH; go++) begin : g_out
    assign dq.out_valid[go] = (count_q > (PTR_W + 1)'(go));
    assign dq.out_info[go]  = entry_q[head_q + PTR_W'(go)];
  end

  assign dq.in_ready = (count_q <= c_ready_max);
  assign w_accept    = dq.in_ready && dq.in_valid[0] && !flush;
  assign count       = count_q;

  // Leading-run counts: a lane counts only if every lower lane counted
  always_comb begin
    w_enq_n = '0;
    w_deq_n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (dq.in_valid[i] && (w_enq_n == (PTR_W + 1)'(i)))
        w_enq_n = w_enq_n + 1'b1;
      if (dq.out_valid[i] && dq.out_ready[i] && (w_deq_n == (PTR_W + 1)'(i)))
        w_deq_n = w_deq_n + 1'b1;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Counts never exceed WIDTH <= DEPTH/2, so the low bits are exact
      head_d  = head_q + w_deq_n[PTR_W-1:0];
      if (w_accept)
        tail_d = tail_q + w_enq_n[PTR_W-1:0];
      count_d = count_q + (w_accept ? w_enq_n : '0) - w_deq_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload needs no reset: occupancy is tracked by count alone
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < WIDTH; i++) begin
        if ((PTR_W + 1)'(i) < w_enq_n)
          entry_q[tail_q + PTR_W'(i)] <= w_dec[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_decode_queue
// Purpose  : Self-checking bench for decode_queue (WIDTH=2, DEPTH=8) with a
//            queue-level reference model and directed decode checks.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int WIDTH = 2;
  localparam int DEPTH = 8;

  localparam logic [31:0] c_nop   = 32'h00000013;
  localparam logic [31:0] c_addi  = 32'h00500093;
  localparam logic [31:0] c_mul   = 32'h022081B3;
  localparam logic [31:0] c_jalr  = 32'h008100E7;
  localparam logic [31:0] c_ill   = 32'hFFFFFFFF;
  localparam logic [31:0] c_divu  = 32'h027352B3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       flush = 1'b0;
  logic [3:0] count;

  decode_queue_if #(.WIDTH(WIDTH)) dq ();

  decode_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .dq    (dq),
    .count (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pcn;
  } exp_t;

  exp_t        mq[$];
  int          n_tests  = 0;
  int          n_fail   = 0;
  logic        check_en = 1'b0;
  logic [31:0] next_pc  = 32'h0000_1000;
  logic [31:0] exp_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of (pc, pc_next) in program order
  always @(negedge rst_n) mq.delete();

  always @(posedge clk) begin
    if (rst_n) begin
      if (flush) begin
        mq.delete();
      end else begin
        automatic int sz  = mq.size();
        automatic int k   = 0;
        automatic bit acc = ((DEPTH - sz) >= WIDTH) && dq.in_valid[0];
        while (k < WIDTH && k < sz && dq.out_ready[k]) k++;
        repeat (k) void'(mq.pop_front());
        if (acc) begin
          for (int l = 0; l < WIDTH; l++) begin
            if (!dq.in_valid[l]) break;
            mq.push_back('{dq.in_pc[l*32 +: 32], dq.in_pc_next[l*32 +: 32]});
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      automatic int sz = mq.size();
      chk("count", 32'(count), 32'(sz));
      chk("in_ready", 32'(dq.in_ready), 32'((DEPTH - sz) >= WIDTH));
      for (int i = 0; i < WIDTH; i++) begin
        chk($sformatf("out_valid[%0d]", i), 32'(dq.out_valid[i]), 32'(sz > i));
        if (sz > i) begin
          chk($sformatf("pc_curr[%0d]", i), dq.out_info[i].pc_curr, mq[i].pc);
          chk($sformatf("pc_next[%0d]", i), dq.out_info[i].pc_next, mq[i].pcn);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1);
    dq.in_valid   = v;
    dq.in_inst    = {i1, i0};
    dq.in_pc      = {next_pc + 32'd4, next_pc};
    dq.in_pc_next = {next_pc + 32'd8, next_pc + 32'd4};
  endtask

  // Present a group for one cycle that is expected to be accepted
  task automatic push(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1);
    drive(v, i0, i1);
    tick();
    dq.in_valid = 2'b00;
    next_pc = next_pc + ((v == 2'b11) ? 32'd8 : 32'd4);
  endtask

  initial begin
    dq.in_valid   = '0;
    dq.in_inst    = '0;
    dq.in_pc      = '0;
    dq.in_pc_next = '0;
    dq.out_ready  = '0;
    #1 rst_n = 1'b0;
    #11;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(dq.out_valid), 32'd0);
    chk("rst_in_ready", 32'(dq.in_ready), 32'd1);
    @(negedge clk);
    rst_n    = 1'b1;
    check_en = 1'b1;
    tick();

    // addi + mul group, held in the queue
    push(2'b11, c_addi, c_mul);
    chk("grp_count", 32'(count), 32'd2);
    chk("grp_out_valid", 32'(dq.out_valid), 32'd3);
    chk("addi_imm", dq.out_info[0].immediate, 32'd5);
    chk("addi_op2imm", 32'(dq.out_info[0].op2_is_imm), 32'd1);
    chk("addi_rd", 32'(dq.out_info[0].rd_s), 32'd1);
    chk("mul_is_mul", 32'(dq.out_info[1].is_mul), 32'd1);
    chk("mul_type", 32'(dq.out_info[1].mul_type), 32'd0);
    chk("mul_alu_en", 32'(dq.out_info[1].alu_en), 32'd0);

    // jalr + illegal behind them; non-prefix out_ready dequeues nothing
    push(2'b11, c_jalr, c_ill);
    chk("q4_count", 32'(count), 32'd4);
    dq.out_ready = 2'b10;
    tick();
    chk("nonprefix_count", 32'(count), 32'd4);
    dq.out_ready = 2'b11;
    tick();
    chk("deq2_count", 32'(count), 32'd2);
    chk("jalr_rs1", 32'(dq.out_info[0].rs1_needed), 32'd1);
    chk("jalr_imm", dq.out_info[0].immediate, 32'd8);
    chk("jalr_jump", 32'(dq.out_info[0].is_jump), 32'd1);
    chk("jalr_cmp_en", 32'(dq.out_info[0].cmp_en), 32'd0);
    chk("ill_illegal", 32'(dq.out_info[1].illegal), 32'd1);
    chk("ill_alu_en", 32'(dq.out_info[1].alu_en), 32'd0);
    chk("ill_rs1", 32'(dq.out_info[1].rs1_needed), 32'd0);

    // simultaneous enqueue of divu/addi and dequeue of two
    push(2'b11, c_divu, c_addi);
    dq.out_ready = 2'b00;
    chk("swap_count", 32'(count), 32'd2);
    chk("divu_is_div", 32'(dq.out_info[0].is_div), 32'd1);
    chk("divu_type", 32'(dq.out_info[0].div_type), 32'd1);
    chk("divu_alu_en", 32'(dq.out_info[0].alu_en), 32'd0);
    dq.out_ready = 2'b11;
    tick();
    dq.out_ready = 2'b00;

    // fill to 7: group refused, then a dequeue reopens in_ready
    push(2'b11, c_nop, c_nop);
    push(2'b11, c_nop, c_nop);
    push(2'b11, c_nop, c_nop);
    push(2'b01, c_nop, c_nop);
    chk("fill_count", 32'(count), 32'd7);
    chk("fill_in_ready", 32'(dq.in_ready), 32'd0);
    drive(2'b11, c_nop, c_nop);
    tick();
    dq.in_valid = 2'b00;
    chk("refused_count", 32'(count), 32'd7);
    dq.out_ready = 2'b11;
    tick();
    chk("reopen_count", 32'(count), 32'd5);
    chk("reopen_in_ready", 32'(dq.in_ready), 32'd1);
    repeat (3) tick();
    chk("drain_count", 32'(count), 32'd0);

    // pointer wrap with mixed group sizes while dequeuing
    begin
      automatic logic [1:0] pat [6] = '{2'b01, 2'b11, 2'b01, 2'b11, 2'b11, 2'b01};
      for (int c = 0; c < 6; c++) push(pat[c], c_nop, c_nop);
    end
    tick();
    chk("wrap_count", 32'(count), 32'd0);
    dq.out_ready = 2'b00;

    // flush beats a same-cycle enqueue and dequeue
    push(2'b11, c_nop, c_nop);
    push(2'b11, c_nop, c_nop);
    chk("preflush_count", 32'(count), 32'd4);
    drive(2'b11, c_nop, c_nop);
    flush        = 1'b1;
    dq.out_ready = 2'b11;
    tick();
    flush        = 1'b0;
    dq.in_valid  = 2'b00;
    dq.out_ready = 2'b00;
    next_pc      = next_pc + 32'd8;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_out_valid", 32'(dq.out_valid), 32'd0);
    exp_pc = next_pc;
    push(2'b01, c_addi, c_nop);
    chk("postflush_count", 32'(count), 32'd1);
    chk("postflush_pc", dq.out_info[0].pc_curr, exp_pc);
    chk("postflush_imm", dq.out_info[0].immediate, 32'd5);
    dq.out_ready = 2'b11;
    tick();
    dq.out_ready = 2'b00;

    // asynchronous reset in the middle of traffic
    push(2'b11, c_nop, c_nop);
    push(2'b11, c_nop, c_nop);
    push(2'b01, c_nop, c_nop);
    chk("prerst_count", 32'(count), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_out_valid", 32'(dq.out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- WIDTH-lane decode stage with a DEPTH-entry circular buffer between fetch and rename.
- Each cycle it accepts a group of up to WIDTH fetched instructions and decodes every lane combinationally into instruction_info_reg_t.
- Decoded entries are enqueued in program order and presented to rename as up to WIDTH oldest entries per cycle, using a valid/ready handshake.
- A flush discards all buffered and in-flight state.

Parameters:
WIDTH, 2, decode/dequeue lanes per cycle (1..4)
DEPTH, 8, queue entries; power of 2, DEPTH >= 2*WIDTH
PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clk  in  1  clock, all state rising-edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  discard queue contents and same-cycle enqueue
in_valid  in  WIDTH  per-lane fetch valid; must be a prefix (lane i valid implies lanes < i valid)
in_inst  in  WIDTH*32  raw instruction per lane
in_pc  in  WIDTH*32  pc_curr per lane
in_pc_next  in  WIDTH*32  predicted pc_next per lane
in_ready  out  1  group accepted this cycle when high
out_info  out  WIDTH x instruction_info_reg_t  oldest entries, lane 0 = oldest
out_valid  out  WIDTH  per-lane entry present (prefix form)
out_ready  in  WIDTH  rename accepts lane; prefix form
count  out  PTR_W+1  occupied entries

Behaviour:
- Reset (async assert, sync-safe deassert): head=tail=0, count=0, out_valid=0, in_ready=1; entry storage is don't-care.
- in_ready = (DEPTH - count) >= WIDTH. Acceptance is combinational on the registered count only and does not depend on same-cycle dequeue.
- Enqueue: when in_ready && in_valid[0] && !flush, popcount(in_valid) decoded lanes are written at tail..tail+n-1 (mod DEPTH) with valid=1. tail advances by n. Partial groups are allowed.
- Latency: an instruction accepted in cycle t is visible on out_valid in cycle t+1 at the earliest (queue is registered, no bypass).
- out_valid[i] = (count > i); out_info[i] = entry[(head+i) mod DEPTH].
- Dequeue: deq_n = number of leading lanes with out_valid & out_ready. head advances by deq_n.
- count_next = count + enq_n - deq_n; simultaneous enqueue and dequeue are legal in the same cycle.
- Pointers wrap modulo DEPTH. Full (count==DEPTH) and empty (count==0) are distinguished by count, never by pointer equality.
- Non-prefix out_ready: only the leading run is honoured. Non-prefix in_valid: lanes after the first 0 are ignored.
- flush: next cycle head=tail=count=0 and out_valid=0. Same-cycle enqueue and dequeue are discarded. flush has priority over everything.
- Decode rules (per lane, rv_decoder):
  - Immediate selection: I/S/B/U/J by opcode.
  - rs1/rs2_needed: set per format; U-type and jal need neither.
  - jalr: rs1_needed=1, op1 is register, immediate=i_imm, is_jump=1, cmp_en=0.
  - lui: immediate=u_imm, op1_is_imm=1 (operand 0), alu_add.
  - auipc: op1 is PC, op2 is immediate.
  - Branches: is_branch=1, cmp_operation=funct3.
  - OP/OP-IMM: slt/sltu map to blt/bltu with alu_en=0; sr and add/sub selected by funct7[5].
  - funct7==0000001 on OP:
    - funct3[2]=0: is_mul=1, mul_type=funct3[1:0].
    - funct3[2]=1: is_div=1, div_type=funct3[1:0].
    - In both cases alu_en=cmp_en=0.
  - Every decoded field (is_mul, is_div, mul_type, div_type, is_branch, is_jump) is driven in every path; no latches.
  - Unknown opcode, or an illegal funct7 on OP/shift-immediate: illegal=1, alu_en=cmp_en=0, rs*_needed=0. The entry is still queued and reported in order.
- rd_s is forced to 0 for store and branch.

Decomposition:
- rv32i_types: add is_div, div_type, illegal to instruction_info_reg_t; add mul_type_t/div_type_t enums; add op_b_lui if missing.
- Sub-module rv_decoder: purely combinational (inst, pc, pc_next -> instruction_info_reg_t), instantiated WIDTH times.
- decode_queue holds only the storage, pointers, count and handshake.

Test Plan:
- Reset then idle: count=0, out_valid=00, in_ready=1. Assert rst_n=0 mid-traffic with count=5 -> immediately count=0, out_valid=00.
- WIDTH=2, enqueue {addi x1,x0,5 (0x00500093); mul x3,x1,x2 (0x022081B3)} with out_ready=00 -> next cycle out_valid=11; lane0 immediate=5, op2_is_imm=1; lane1 is_mul=1, mul_type=00, alu_en=0.
- Fill to count=7 with out_ready=00 -> in_ready=0; a group presented that cycle is not accepted and count stays 7. Then out_ready=11 -> count=5 and in_ready=1.
- Wrap: 6 enqueue/dequeue cycles with DEPTH=8, interleaving 1-lane and 2-lane groups -> output pc sequence strictly increasing by 4, no loss or duplicate across pointer wrap.
- Simultaneous enqueue of 2 and flush while count=4 -> next cycle count=0, out_valid=00; the following group appears first at head=0.
- Decode: jalr x1,8(x2) (0x008100E7) -> rs1_needed=1, immediate=8, is_jump=1. 0xFFFFFFFF -> illegal=1, alu_en=0. divu x5,x6,x7 (0x027352B3) -> is_div=1, div_type=01. out_ready=10 with out_valid=11 -> nothing dequeued.
